// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive datapath
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        ERR  = 2'd2
    } rx_sipo_state_t;

    localparam logic J_LEVEL       = 1'b1;
    localparam int   USB_STUFF_LEN = 6;

endpackage

// File: rtl/usb_rx_nrzi_unstuff.sv
// rtl/usb_rx_nrzi_unstuff.sv - NRZI decode and bit-unstuffing of sampled line levels
module usb_rx_nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sample,
    input  logic d_line,
    output logic bit_valid,
    output logic bit_data,
    output logic stuff_viol
);

    localparam int ONES_W = $clog2(STUFF_LEN + 1);

    logic              prev_level;
    logic [ONES_W-1:0] ones;
    logic              dec;
    logic              stuff_slot;

    assign dec        = (d_line == prev_level);
    assign stuff_slot = (ones == ONES_W'(STUFF_LEN));

    // Strobes are combinational in the sample cycle; the top level registers them.
    always_comb begin
        bit_valid  = 1'b0;
        bit_data   = dec;
        stuff_viol = 1'b0;
        if (sample) begin
            if (stuff_slot) begin
                stuff_viol = dec;
            end else begin
                bit_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prev_level <= J_LEVEL;
            ones       <= '0;
        end else if (sample) begin
            prev_level <= d_line;
            if (stuff_slot) begin
                ones <= '0;
            end else begin
                ones <= dec ? ones + 1'b1 : '0;
            end
        end
    end

endmodule

// File: rtl/usb_rx_sipo_unstuff.sv
// rtl/usb_rx_sipo_unstuff.sv - USB RX NRZI decode, unstuff and LSB-first byte assembly
module usb_rx_sipo_unstuff
    import usb_rx_pkg::*;
#(
    parameter int NUM_BITS  = 8,
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic                d_line,
    input  logic                rcving,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                byte_valid,
    output logic                stuff_err,
    output logic                align_err,
    output logic [2:0]          bit_cnt
);

    rx_sipo_state_t      state;
    rx_sipo_state_t      state_next;
    logic [NUM_BITS-1:0] shift_reg;
    logic [NUM_BITS-1:0] shift_next;
    logic                clear;
    logic                sample;
    logic                align_set;
    logic                bit_valid;
    logic                bit_data;
    logic                stuff_viol;
    logic                byte_done;

    // A falling rcving outranks a coincident sample, so samples only count while rcving holds.
    assign sample     = sample_en && rcving && (state == RECV);
    assign shift_next = {bit_data, shift_reg[NUM_BITS-1:1]};
    assign byte_done  = (bit_cnt == 3'(NUM_BITS - 1));

    usb_rx_nrzi_unstuff #(
        .STUFF_LEN(STUFF_LEN)
    ) u_nrzi (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sample    (sample),
        .d_line    (d_line),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .stuff_viol(stuff_viol)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        align_set  = 1'b0;
        case (state)
            IDLE: begin
                clear = 1'b1;
                if (rcving) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (!rcving) begin
                    state_next = IDLE;
                    align_set  = (bit_cnt != 3'd0);
                end else if (stuff_viol) begin
                    state_next = ERR;
                end
            end
            ERR: begin
                if (!rcving) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            stuff_err  <= 1'b0;
            align_err  <= 1'b0;
            bit_cnt    <= 3'd0;
        end else begin
            byte_valid <= 1'b0;
            stuff_err  <= stuff_viol;
            align_err  <= align_set;
            if (clear || state_next == IDLE) begin
                bit_cnt <= 3'd0;
            end else if (bit_valid) begin
                shift_reg <= shift_next;
                bit_cnt   <= byte_done ? 3'd0 : bit_cnt + 3'd1;
                if (byte_done) begin
                    rx_data    <= shift_next;
                    byte_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_sipo_unstuff.sv
// tb/tb_usb_rx_sipo_unstuff.sv - self-checking bench for usb_rx_sipo_unstuff
module tb_usb_rx_sipo_unstuff;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic       d_line;
    logic       rcving;
    logic [7:0] rx_data;
    logic       byte_valid;
    logic       stuff_err;
    logic       align_err;
    logic [2:0] bit_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: 0 idle, 1 receiving, 2 error-wait
    int   m_mode;
    logic m_prev;
    int   m_run;
    logic m_bits[$];
    logic [7:0] m_rx;

    // Line encoder state
    logic tx_level;
    int   tx_run;

    usb_rx_sipo_unstuff dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .d_line    (d_line),
        .rcving    (rcving),
        .rx_data   (rx_data),
        .byte_valid(byte_valid),
        .stuff_err (stuff_err),
        .align_err (align_err),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic bv, input logic se, input logic ae);
        check({tag, ".byte_valid"}, 32'(byte_valid), 32'(bv));
        check({tag, ".stuff_err"},  32'(stuff_err),  32'(se));
        check({tag, ".align_err"},  32'(align_err),  32'(ae));
        check({tag, ".rx_data"},    32'(rx_data),    32'(m_rx));
        if (m_mode != 2)
            check({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(m_bits.size()));
    endtask

    task automatic send_level(input string tag, input logic lv);
        logic e_bv;
        logic e_se;
        logic dec;
        e_bv = 1'b0;
        e_se = 1'b0;
        tx_run   = (lv == tx_level) ? tx_run + 1 : 0;
        tx_level = lv;
        if (m_mode == 1 && rcving) begin
            dec    = (lv == m_prev);
            m_prev = lv;
            if (m_run == 6) begin
                if (dec) begin
                    e_se   = 1'b1;
                    m_mode = 2;
                end
                m_run = 0;
            end else begin
                m_run = dec ? m_run + 1 : 0;
                m_bits.push_back(dec);
                if (m_bits.size() == 8) begin
                    m_rx = '0;
                    for (int i = 0; i < 8; i++) m_rx = m_rx | (8'(m_bits[i]) << i);
                    m_bits.delete();
                    e_bv = 1'b1;
                end
            end
        end
        d_line    = lv;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check_outs(tag, e_bv, e_se, 1'b0);
        tick();
        check_outs({tag, ".gap"}, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_level(tag, b[i] ? tx_level : ~tx_level);
            if (tx_run == 6) send_level({tag, ".stuff"}, ~tx_level);
        end
    endtask

    task automatic start_pkt();
        rcving   = 1'b1;
        tx_level = 1'b1;
        tx_run   = 0;
        m_mode   = 1;
        m_prev   = 1'b1;
        m_run    = 0;
        m_bits.delete();
        tick();
        check_outs("start", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic end_pkt(input string tag, input logic coincide);
        logic e_ae;
        e_ae   = (m_mode == 1) && (m_bits.size() != 0);
        m_mode = 0;
        m_bits.delete();
        rcving = 1'b0;
        if (coincide) begin
            d_line    = ~tx_level;
            sample_en = 1'b1;
        end
        tick();
        sample_en = 1'b0;
        check_outs(tag, 1'b0, 1'b0, e_ae);
        tick();
        check_outs({tag, ".gap"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] sync_lv;
        rst       = 1'b1;
        sample_en = 1'b0;
        d_line    = 1'b1;
        rcving    = 1'b0;
        m_mode    = 0;
        m_rx      = 8'h00;
        tx_level  = 1'b1;
        tx_run    = 0;
        tick();
        tick();
        rst = 1'b0;
        check_outs("reset", 1'b0, 1'b0, 1'b0);

        // Sample in IDLE is ignored
        send_level("idle_sample", 1'b0);

        // SYNC: levels 0,1,0,1,0,1,0,0 -> 0x80
        sync_lv = 8'b0010_1010;
        start_pkt();
        for (int i = 0; i < 8; i++) send_level("sync", sync_lv[i]);
        check("sync.value", 32'(rx_data), 32'h80);
        end_pkt("sync.end", 1'b0);

        // 0xFF with one stuffed zero
        start_pkt();
        send_byte("ff", 8'hFF);
        check("ff.value", 32'(rx_data), 32'hFF);
        end_pkt("ff.end", 1'b0);

        // Stuff violation: seven unchanged levels, then ignored samples
        start_pkt();
        for (int i = 0; i < 7; i++) send_level("viol", 1'b1);
        for (int i = 0; i < 4; i++) send_level("viol.ignored", 1'($urandom_range(0, 1)));
        end_pkt("viol.end", 1'b0);

        // Partial byte
        start_pkt();
        for (int i = 0; i < 5; i++) send_level("partial", 1'($urandom_range(0, 1)));
        end_pkt("partial.end", 1'b0);

        // Reset mid-byte, then clean 0x3C
        start_pkt();
        for (int i = 0; i < 4; i++) send_level("pre_rst", ~tx_level);
        rst    = 1'b1;
        rcving = 1'b0;
        tick();
        rst    = 1'b0;
        m_mode = 0;
        m_rx   = 8'h00;
        m_bits.delete();
        check_outs("mid_reset", 1'b0, 1'b0, 1'b0);
        start_pkt();
        send_byte("b3c", 8'h3C);
        check("b3c.value", 32'(rx_data), 32'h3C);
        end_pkt("b3c.end", 1'b0);

        // Coincident sample on would-be bit 8
        start_pkt();
        for (int i = 0; i < 7; i++) send_level("coin", ~tx_level);
        check("coin.cnt7", 32'(bit_cnt), 32'd7);
        end_pkt("coin.end", 1'b1);

        // Random multi-byte packets
        for (int p = 0; p < 12; p++) begin
            start_pkt();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                send_byte("rand_byte", 8'($urandom));
            end_pkt("rand_byte.end", 1'b0);
        end

        // Random raw line levels, biased toward runs so stuffing paths occur
        for (int p = 0; p < 12; p++) begin
            start_pkt();
            for (int k = 0; k < int'($urandom_range(3, 30)); k++)
                send_level("rand_lv", ($urandom_range(0, 3) == 0) ? ~tx_level : tx_level);
            end_pkt("rand_lv.end", 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
